// File: rtl/apple_placer.sv
// Apple placement for the snake grid: an LFSR picks a start cell, then a
// one-cell-per-clock wrap-around scan finds the first unoccupied cell.
module apple_placer #(
  parameter int         GRID_COLS = 7,
  parameter int         GRID_ROWS = 6,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_n,
  input  logic                           i_Start,
  input  logic                           i_Clear,
  input  logic [GRID_COLS*GRID_ROWS-1:0] i_Occupied,
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic                           o_Valid,
  output logic                           o_Full,
  output logic [2:0]                     o_Apple_X,
  output logic [2:0]                     o_Apple_Y
);

  localparam int         CELLS     = GRID_COLS * GRID_ROWS;
  localparam logic [5:0] NUM_CELLS = 6'(CELLS);
  localparam logic [5:0] LAST_CELL = 6'(CELLS - 1);
  localparam logic [2:0] LAST_COL  = 3'(GRID_COLS - 1);
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_INIT = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  lfsr_reg, lfsr_next;
  logic [5:0]  cand_reg, cand_next;
  logic [2:0]  cand_x_reg, cand_x_next;
  logic [2:0]  cand_y_reg, cand_y_next;
  logic [5:0]  scan_cnt_reg, scan_cnt_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        valid_reg, valid_next;
  logic        full_reg, full_next;
  logic [2:0]  apple_x_reg, apple_x_next;
  logic [2:0]  apple_y_reg, apple_y_next;

  logic [63:0] occ_pad;
  logic [2:0]  cell_x [64];
  logic [2:0]  cell_y [64];
  logic [5:0]  start_raw;
  logic [5:0]  start_cell;

  // Constant cell->(X,Y) table so the start cell needs no runtime divider;
  // pad cells read as occupied and are never reached.
  for (genvar gi = 0; gi < 64; gi++) begin : g_cell
    if (gi < CELLS) begin : g_real
      assign occ_pad[gi] = i_Occupied[gi];
      assign cell_x[gi]  = 3'(gi % GRID_COLS);
      assign cell_y[gi]  = 3'(gi / GRID_COLS);
    end else begin : g_pad
      assign occ_pad[gi] = 1'b1;
      assign cell_x[gi]  = 3'd0;
      assign cell_y[gi]  = 3'd0;
    end
  end

  assign lfsr_next  = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 8'h00);
  assign start_raw  = lfsr_reg[5:0];
  assign start_cell = (start_raw >= NUM_CELLS) ? (start_raw - NUM_CELLS) : start_raw;

  always_comb begin
    state_next    = state_reg;
    cand_next     = cand_reg;
    cand_x_next   = cand_x_reg;
    cand_y_next   = cand_y_reg;
    scan_cnt_next = scan_cnt_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    valid_next    = valid_reg;
    full_next     = full_reg;
    apple_x_next  = apple_x_reg;
    apple_y_next  = apple_y_reg;

    if (i_Clear) begin
      state_next = ST_IDLE;
      busy_next  = 1'b0;
      valid_next = 1'b0;
      full_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_Start) begin
            cand_next     = start_cell;
            cand_x_next   = cell_x[start_cell];
            cand_y_next   = cell_y[start_cell];
            scan_cnt_next = 6'd0;
            busy_next     = 1'b1;
            state_next    = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!occ_pad[cand_reg]) begin
            apple_x_next = cand_x_reg;
            apple_y_next = cand_y_reg;
            valid_next   = 1'b1;
            full_next    = 1'b0;
            done_next    = 1'b1;
            busy_next    = 1'b0;
            state_next   = ST_IDLE;
          end else if (scan_cnt_reg == LAST_CELL) begin
            valid_next = 1'b0;
            full_next  = 1'b1;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            scan_cnt_next = scan_cnt_reg + 6'd1;
            if (cand_reg == LAST_CELL) begin
              cand_next   = 6'd0;
              cand_x_next = 3'd0;
              cand_y_next = 3'd0;
            end else begin
              cand_next = cand_reg + 6'd1;
              if (cand_x_reg == LAST_COL) begin
                cand_x_next = 3'd0;
                cand_y_next = cand_y_reg + 3'd1;
              end else begin
                cand_x_next = cand_x_reg + 3'd1;
              end
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg    <= ST_IDLE;
      lfsr_reg     <= LFSR_INIT;
      cand_reg     <= 6'd0;
      cand_x_reg   <= 3'd0;
      cand_y_reg   <= 3'd0;
      scan_cnt_reg <= 6'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      full_reg     <= 1'b0;
      apple_x_reg  <= 3'd0;
      apple_y_reg  <= 3'd0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      cand_reg     <= cand_next;
      cand_x_reg   <= cand_x_next;
      cand_y_reg   <= cand_y_next;
      scan_cnt_reg <= scan_cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      valid_reg    <= valid_next;
      full_reg     <= full_next;
      apple_x_reg  <= apple_x_next;
      apple_y_reg  <= apple_y_next;
    end
  end

  assign o_Busy    = busy_reg;
  assign o_Done    = done_reg;
  assign o_Valid   = valid_reg;
  assign o_Full    = full_reg;
  assign o_Apple_X = apple_x_reg;
  assign o_Apple_Y = apple_y_reg;

endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer: three instances with different LFSR seeds
// share control inputs; each has its own occupancy map.
module tb_apple_placer;

  logic        clk = 1'b0;
  logic        rst_n, start, clear;
  logic [41:0] occ_a, occ_b, occ_c;
  logic        busy_a, done_a, valid_a, full_a;
  logic        busy_b, done_b, valid_b, full_b;
  logic        busy_c, done_c, valid_c, full_c;
  logic [2:0]  x_a, y_a, x_b, y_b, x_c, y_c;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int dcnt;

  always #5 clk = ~clk;

  apple_placer #(.LFSR_SEED(8'hA5)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Clear(clear),
    .i_Occupied(occ_a), .o_Busy(busy_a), .o_Done(done_a), .o_Valid(valid_a),
    .o_Full(full_a), .o_Apple_X(x_a), .o_Apple_Y(y_a)
  );

  apple_placer #(.LFSR_SEED(8'h29)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Clear(clear),
    .i_Occupied(occ_b), .o_Busy(busy_b), .o_Done(done_b), .o_Valid(valid_b),
    .o_Full(full_b), .o_Apple_X(x_b), .o_Apple_Y(y_b)
  );

  apple_placer #(.LFSR_SEED(8'h3F)) dut_c (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Clear(clear),
    .i_Occupied(occ_c), .o_Busy(busy_c), .o_Done(done_c), .o_Valid(valid_c),
    .o_Full(full_c), .o_Apple_X(x_c), .o_Apple_Y(y_c)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_xy(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    occ_a = '0; occ_b = '0; occ_c = '0;
    occ_b[41] = 1'b1;
    repeat (2) @(negedge clk);
    chk_bit("rst_busy", busy_a, 1'b0);
    chk_bit("rst_done", done_a, 1'b0);
    chk_bit("rst_valid", valid_a, 1'b0);
    chk_bit("rst_full", full_a, 1'b0);
    chk_xy("rst_x", x_a, 3'd0);
    chk_xy("rst_y", y_a, 3'd0);

    // Test 1/3/4: start on the first edge after reset
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_bit("t1_busy", busy_a, 1'b1);
    chk_bit("t1_early_done", done_a, 1'b0);
    @(negedge clk);
    chk_bit("t1_done", done_a, 1'b1);
    chk_bit("t1_valid", valid_a, 1'b1);
    chk_bit("t1_full", full_a, 1'b0);
    chk_bit("t1_busy_off", busy_a, 1'b0);
    chk_xy("t1_x", x_a, 3'd2);
    chk_xy("t1_y", y_a, 3'd5);
    chk_bit("t4_done", done_c, 1'b1);
    chk_bit("t4_valid", valid_c, 1'b1);
    chk_bit("t4_full", full_c, 1'b0);
    chk_bit("t4_busy", busy_c, 1'b0);
    chk_xy("t4_x", x_c, 3'd0);
    chk_xy("t4_y", y_c, 3'd3);
    chk_bit("t3_busy", busy_b, 1'b1);
    chk_bit("t3_early_done", done_b, 1'b0);
    $display("txn t1 placed x=%0d y=%0d; t4 placed x=%0d y=%0d", x_a, y_a, x_c, y_c);
    @(negedge clk);
    chk_bit("t1_pulse", done_a, 1'b0);
    chk_bit("t1_valid_hold", valid_a, 1'b1);
    chk_bit("t3_done", done_b, 1'b1);
    chk_bit("t3_valid", valid_b, 1'b1);
    chk_bit("t3_full", full_b, 1'b0);
    chk_xy("t3_x", x_b, 3'd0);
    chk_xy("t3_y", y_b, 3'd0);
    $display("txn t3 wrapped to x=%0d y=%0d", x_b, y_b);

    // Test 2: cell 37 occupied -> one extra cycle, cell 38
    rst_n = 1'b0;
    #1;
    chk_bit("t2_async_rst_valid", valid_a, 1'b0);
    @(negedge clk);
    occ_a = '0; occ_a[37] = 1'b1;
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_bit("t2_not_yet", done_a, 1'b0);
    chk_bit("t2_busy", busy_a, 1'b1);
    @(negedge clk);
    chk_bit("t2_done", done_a, 1'b1);
    chk_xy("t2_x", x_a, 3'd3);
    chk_xy("t2_y", y_a, 3'd5);
    $display("txn t2 placed x=%0d y=%0d", x_a, y_a);

    // Held start: accepted at edge 0 and again at edge 2 (LFSR 0x75 -> cell 11)
    rst_n = 1'b0;
    @(negedge clk);
    occ_a = '0;
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    chk_bit("hold_busy0", busy_a, 1'b1);
    @(negedge clk);
    chk_bit("hold_done1", done_a, 1'b1);
    chk_xy("hold_x1", x_a, 3'd2);
    chk_xy("hold_y1", y_a, 3'd5);
    @(negedge clk);
    start = 1'b0;
    chk_bit("hold_busy2", busy_a, 1'b1);
    chk_bit("hold_nodone2", done_a, 1'b0);
    @(negedge clk);
    chk_bit("hold_done3", done_a, 1'b1);
    chk_xy("hold_x3", x_a, 3'd4);
    chk_xy("hold_y3", y_a, 3'd1);
    @(negedge clk);
    chk_bit("hold_nodone4", done_a, 1'b0);
    chk_bit("hold_idle4", busy_a, 1'b0);
    $display("txn held-start second result x=%0d y=%0d", x_a, y_a);

    // Test 5: full board, previous apple (4,1) must be kept
    occ_a = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    chk_int("t5_busy_cycles", cyc, 42);
    chk_bit("t5_done", done_a, 1'b1);
    chk_bit("t5_full", full_a, 1'b1);
    chk_bit("t5_valid", valid_a, 1'b0);
    chk_xy("t5_x_kept", x_a, 3'd4);
    chk_xy("t5_y_kept", y_a, 3'd1);
    $display("txn t5 full board after %0d busy cycles", cyc);
    occ_a[17] = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 60) begin
      cyc++;
      @(negedge clk);
    end
    chk_bit("t5b_done", done_a, 1'b1);
    chk_xy("t5b_x", x_a, 3'd3);
    chk_xy("t5b_y", y_a, 3'd2);
    chk_bit("t5b_full", full_a, 1'b0);
    chk_bit("t5b_valid", valid_a, 1'b1);
    $display("txn t5b placed x=%0d y=%0d", x_a, y_a);

    // Test 6a: reset in the middle of a scan
    occ_a = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk_bit("t6_scanning", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("t6_rst_busy", busy_a, 1'b0);
    chk_bit("t6_rst_valid", valid_a, 1'b0);
    chk_bit("t6_rst_done", done_a, 1'b0);
    chk_xy("t6_rst_x", x_a, 3'd0);
    chk_xy("t6_rst_y", y_a, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_a) dcnt++;
    end
    chk_int("t6_rst_no_done", dcnt, 0);
    $display("txn t6 reset mid-scan");

    // Test 6b: clear during a scan, asserted together with start
    occ_a = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_bit("t6_pre_valid", valid_a, 1'b1);
    occ_a = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk_bit("t6_clr_busy", busy_a, 1'b0);
    chk_bit("t6_clr_valid", valid_a, 1'b0);
    chk_bit("t6_clr_full", full_a, 1'b0);
    chk_bit("t6_clr_done", done_a, 1'b0);
    dcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_a) dcnt++;
    end
    chk_int("t6_clr_no_done", dcnt, 0);
    $display("txn t6 clear mid-scan");

    // Test 6c: clear on the same edge a free cell would be reported
    occ_a = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_bit("t6c_done", done_a, 1'b0);
    chk_bit("t6c_valid", valid_a, 1'b0);
    chk_bit("t6c_busy", busy_a, 1'b0);
    @(negedge clk);
    chk_bit("t6c_done_late", done_a, 1'b0);
    $display("txn t6 clear beats result");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
